// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared width, FSM state and owner encodings for the fetch/data memory arbiter.
`ifndef XLEN
`define XLEN 32
`endif

package riscv_mem_arbiter_pkg;

  localparam int XLEN = `XLEN;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IF = 1'b0,
    ARB_OWN_DM = 1'b1
  } arb_owner_e;

  function automatic logic is_word_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Single-port memory bus: the arbiter is the master, the unified memory the slave.
interface riscv_mem_arbiter_if;
  import riscv_mem_arbiter_pkg::*;

  logic            req;
  logic            we;
  logic [3:0]      byte_sel;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, byte_sel, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, byte_sel, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/riscv_arb_watchdog.sv
// Transaction watchdog: counts while enabled, flags the cycle in which TIMEOUT_CYCLES is reached.
module riscv_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [7:0] TcVal = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else if (clr_i) begin
      cnt_q <= 8'd0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 8'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  // tc fires during the TIMEOUT_CYCLES-th enabled cycle, i.e. as the count reaches the limit
  assign tc_o = en_i & (cnt_q == TcVal);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter for one single-port memory, one transaction in flight, watchdog-bounded.
// Optional macro RISCV_ARB_ROUND_ROBIN_EN: last-served requester loses simultaneous arbitration.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          ADDR_ALIGN_CHK = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [XLEN-1:0]     i_if_addr,
  output logic [XLEN-1:0]     o_if_rdata,
  output logic                o_if_valid,
  output logic                o_if_stall,
  input  logic                i_dm_req,
  input  logic                i_dm_we,
  input  logic [3:0]          i_dm_byte_sel,
  input  logic [XLEN-1:0]     i_dm_addr,
  input  logic [XLEN-1:0]     i_dm_wdata,
  output logic [XLEN-1:0]     o_dm_rdata,
  output logic                o_dm_valid,
  output logic                o_dm_stall,
  riscv_mem_arbiter_if.master mem,
  output logic                o_err
);

  arb_state_e      state_q;
  arb_owner_e      owner_q;
  arb_owner_e      owner_d;
  logic            any_req_d;
  logic            misalign_d;
  logic            wd_tc;
  logic [XLEN-1:0] rsp_rdata_d;

  logic            mem_req_q;
  logic            mem_we_q;
  logic [3:0]      mem_sel_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic            if_valid_q;
  logic            dm_valid_q;
  logic            err_q;
  logic [XLEN-1:0] if_rdata_q;
  logic [XLEN-1:0] dm_rdata_q;

`ifdef RISCV_ARB_ROUND_ROBIN_EN
  arb_owner_e last_q;

  always_comb begin
    owner_d = ARB_OWN_IF;
    if (i_dm_req && i_if_req) begin
      owner_d = (last_q == ARB_OWN_DM) ? ARB_OWN_IF : ARB_OWN_DM;
    end else if (i_dm_req) begin
      owner_d = ARB_OWN_DM;
    end else begin
      owner_d = ARB_OWN_IF;
    end
  end
`else
  // DM holds the older instruction, so it wins ties
  always_comb begin
    owner_d = i_dm_req ? ARB_OWN_DM : ARB_OWN_IF;
  end
`endif

  assign any_req_d   = i_if_req | i_dm_req;
  assign misalign_d  = ADDR_ALIGN_CHK && (owner_d == ARB_OWN_IF) && is_word_misaligned(i_if_addr[1:0]);
  assign rsp_rdata_d = mem_we_q ? '0 : mem.rdata;

  riscv_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .clr_i (state_q != ARB_WAIT),
    .en_i  (state_q == ARB_WAIT),
    .tc_o  (wd_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
`ifdef RISCV_ARB_ROUND_ROBIN_EN
      last_q      <= ARB_OWN_IF;
`endif
    end else begin
      // response fields are single-cycle pulses unless set below
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (any_req_d) begin
            owner_q <= owner_d;
            if (misalign_d) begin
              state_q    <= ARB_RESP;
              err_q      <= 1'b1;
              if_valid_q <= 1'b1;
            end else begin
              state_q     <= ARB_ISSUE;
              mem_req_q   <= 1'b1;
              mem_we_q    <= (owner_d == ARB_OWN_DM) ? i_dm_we : 1'b0;
              mem_sel_q   <= (owner_d == ARB_OWN_DM) ? i_dm_byte_sel : 4'hF;
              mem_addr_q  <= (owner_d == ARB_OWN_DM) ? i_dm_addr : i_if_addr;
              mem_wdata_q <= (owner_d == ARB_OWN_DM) ? i_dm_wdata : '0;
            end
          end else begin
            state_q <= ARB_IDLE;
          end
        end
        ARB_ISSUE: begin
          if (mem.gnt) begin
            state_q   <= ARB_WAIT;
            mem_req_q <= 1'b0;
          end else begin
            state_q <= ARB_ISSUE;
          end
        end
        ARB_WAIT: begin
          if (mem.rvalid || wd_tc) begin
            state_q <= ARB_RESP;
            err_q   <= ~mem.rvalid;
            if (owner_q == ARB_OWN_DM) begin
              dm_valid_q <= 1'b1;
              dm_rdata_q <= mem.rvalid ? rsp_rdata_d : '0;
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= mem.rvalid ? rsp_rdata_d : '0;
            end
          end else begin
            state_q <= ARB_WAIT;
          end
        end
        ARB_RESP: begin
          state_q <= ARB_IDLE;
`ifdef RISCV_ARB_ROUND_ROBIN_EN
          last_q  <= owner_q;
`endif
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign mem.req      = mem_req_q;
  assign mem.we       = mem_we_q;
  assign mem.byte_sel = mem_sel_q;
  assign mem.addr     = mem_addr_q;
  assign mem.wdata    = mem_wdata_q;

  assign o_if_valid = if_valid_q;
  assign o_if_rdata = if_rdata_q;
  assign o_dm_valid = dm_valid_q;
  assign o_dm_rdata = dm_rdata_q;
  assign o_err      = err_q;
  assign o_if_stall = i_if_req & ~if_valid_q;
  assign o_dm_stall = i_dm_req & ~dm_valid_q;

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the pipelined RV32I core. It serialises the requests and allows one outstanding memory transaction at a time. It produces per-requester stall signals for the hazard unit and a one-cycle response pulse to each stage. A watchdog bounds every transaction.

Parameters:
TIMEOUT_CYCLES, 64, WAIT-state cycles before a transaction is abandoned; legal range 2..255
ADDR_ALIGN_CHK, 1, when 1, misaligned word fetch (i_if_addr[1:0]!=0) is rejected with o_err, no memory access

Ports:
i_clk           input   1      clock, all logic on rising edge
i_rst           input   1      reset; one clock; reset is synchronous and active-high
i_if_req        input   1      fetch read request, held until o_if_valid
i_if_addr       input   XLEN   fetch address
o_if_rdata      output  XLEN   fetch read data, valid with o_if_valid
o_if_valid      output  1      one-cycle fetch completion pulse
o_if_stall      output  1      i_if_req & ~o_if_valid
i_dm_req        input   1      data request, held until o_dm_valid
i_dm_we         input   1      1=store, 0=load
i_dm_byte_sel   input   4      store byte enables
i_dm_addr       input   XLEN   data address
i_dm_wdata      input   XLEN   store data
o_dm_rdata      output  XLEN   load data, valid with o_dm_valid
o_dm_valid      output  1      one-cycle data completion pulse
o_dm_stall      output  1      i_dm_req & ~o_dm_valid
o_mem_req       output  1      memory request, held until i_mem_gnt
o_mem_we        output  1      memory write enable
o_mem_byte_sel  output  4      memory byte enables (4'hF for fetch)
o_mem_addr      output  XLEN   memory address
o_mem_wdata     output  XLEN   memory write data
i_mem_gnt       input   1      memory accepts request this cycle
i_mem_rvalid    input   1      response/ack (reads and writes)
i_mem_rdata     input   XLEN   memory read data
o_err           output  1      one-cycle pulse on timeout or misalignment

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. An owner register (IF/DM) is captured on leaving IDLE.
- Reset: state=IDLE, owner=IF. All o_mem_*, o_*_valid, o_*_rdata and o_err are 0. The watchdog counter is 0.
- IDLE: if any request is present, latch owner, address, we, byte_sel and wdata into registers, then go to ISSUE. Default priority is DM over IF (DM holds the older instruction).
- ISSUE: drive o_mem_req=1 and the latched fields. On i_mem_gnt go to WAIT, otherwise hold.
- WAIT: the counter increments each cycle.
  - On i_mem_rvalid: capture i_mem_rdata, go to RESP.
  - When the counter reaches TIMEOUT_CYCLES: go to RESP with rdata=0 and pulse o_err.
  - i_mem_rvalid outside WAIT is ignored.
- RESP: pulse the owner's o_*_valid and present the registered rdata, then return to IDLE. For stores, rdata=0.
- Minimum latency is 3 cycles from request to valid (gnt in first ISSUE cycle, rvalid in first WAIT cycle). Back-to-back: the next arbitration happens in the IDLE cycle after RESP.
- Simultaneous IF and DM requests in IDLE: DM wins. IF stays stalled and is served next.
- A requester dropping its req mid-transaction is a protocol violation. The transaction still completes and the valid pulse still fires.
- Misaligned fetch with ADDR_ALIGN_CHK=1: IDLE goes directly to RESP. o_err pulses, o_if_rdata=0, and o_mem_req is never raised.
- Reset mid-transaction: return to IDLE immediately and drop o_mem_req. A later stale rvalid is ignored.
- Stall outputs are combinational. All other outputs are registered.

Optional Feature:
RISCV_ARB_ROUND_ROBIN_EN
- Defined: a last-served flag, updated in RESP, selects the winner on simultaneous requests. The requester served last loses. This bounds IF starvation to one DM transaction.
- Undefined: fixed DM-over-IF priority, and no last-served flag exists.

Decomposition:
- The shared configs header holds `XLEN and the state encodings: ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_WAIT=2'd2, ARB_RESP=2'd3. It also holds the owner encodings ARB_OWN_IF=1'b0 and ARB_OWN_DM=1'b1.
- One natural sub-module, riscv_arb_watchdog: a counter with clear/enable and a terminal-count output compared to TIMEOUT_CYCLES.

Test Plan:
1. IF read only, addr 0x0000_0010, gnt immediate, rvalid 1 cycle later with rdata 0x0050_0093 -> o_mem_req 1 cycle; o_if_valid at cycle 3 with rdata 0x0050_0093; o_if_stall high cycles 0-2.
2. Simultaneous IF (0x14) and DM store (0x100, data 0xDEAD_BEEF, sel 4'hF) -> DM served first with o_mem_we=1; IF issued in the IDLE cycle after DM RESP. With RISCV_ARB_ROUND_ROBIN_EN after a prior DM, IF wins.
3. gnt delayed 4 cycles -> o_mem_req and address stable all 4 cycles; valid at cycle 7.
4. rvalid never arrives, TIMEOUT_CYCLES=8 -> o_err and o_dm_valid pulse together 8 WAIT cycles after gnt, rdata 0.
5. Reset asserted in WAIT, rvalid arrives the cycle after -> no valid pulse, state IDLE, all outputs 0.
6. Fetch at 0x0000_0002 with ADDR_ALIGN_CHK=1 -> o_err and o_if_valid pulse at cycle 1, o_mem_req never asserted.
